// File: rtl/e1chbuf.sv
// e1chbuf: per-channel elastic byte buffer (21 circular FIFOs in one RAM) with ovf/udf pulses.
// Optional sticky per-channel alarms when E1CHBUF_ALARM_EN is defined.
module e1chbuf #(
  parameter int WID = 8,
  parameter int DEPTH_BIT = 3,
  localparam int NCHANEL = 21,
  localparam int CHNBIT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHNBIT-1:0]    iid,
  input  logic [WID-1:0]       di,
  input  logic                 divld,
  input  logic [CHNBIT-1:0]    rid,
  input  logic                 rreq,
  output logic [WID-1:0]       dout,
  output logic                 dovld,
  output logic [DEPTH_BIT:0]   fill,
  output logic                 ovf,
  output logic                 udf
`ifdef E1CHBUF_ALARM_EN
  ,
  input  logic                 almclr,
  output logic [NCHANEL-1:0]   ovfalm,
  output logic [NCHANEL-1:0]   udfalm
`endif
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] FULL = (DEPTH_BIT+1)'(DEPTH);
  logic [WID-1:0] mem [NCHANEL*DEPTH];
  logic [DEPTH_BIT-1:0] wp [NCHANEL];
  logic [DEPTH_BIT-1:0] rp [NCHANEL];
  logic [DEPTH_BIT:0] cnt [NCHANEL];
  logic wv, rv, wok, rok;
  always_comb begin
    wv = divld && (iid < CHNBIT'(NCHANEL));
    rv = rreq && (rid < CHNBIT'(NCHANEL));
    wok = wv && (cnt[iid] != FULL);
    rok = rv && (cnt[rid] != '0);
  end
  // Full/empty use start-of-cycle counts, so write and read never hit the same RAM slot.
  always_ff @(posedge clk)
    if (wok) mem[{iid, wp[iid]}] <= di;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < NCHANEL; c++) begin
        wp[c] <= '0;
        rp[c] <= '0;
        cnt[c] <= '0;
      end
      dout <= '0;
      dovld <= 1'b0;
      fill <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      for (int c = 0; c < NCHANEL; c++) begin
        if (wok && iid == CHNBIT'(c)) wp[c] <= wp[c] + DEPTH_BIT'(1);
        if (rok && rid == CHNBIT'(c)) rp[c] <= rp[c] + DEPTH_BIT'(1);
        if ((wok && iid == CHNBIT'(c)) != (rok && rid == CHNBIT'(c)))
          cnt[c] <= (wok && iid == CHNBIT'(c)) ? cnt[c] + (DEPTH_BIT+1)'(1) : cnt[c] - (DEPTH_BIT+1)'(1);
      end
      dout <= rok ? mem[{rid, rp[rid]}] : '0;
      dovld <= rok;
      fill <= rv ? cnt[rid] : '0;
      ovf <= wv && !wok;
      udf <= rv && !rok;
    end
`ifdef E1CHBUF_ALARM_EN
  logic [NCHANEL-1:0] ovfset, udfset;
  always_comb begin
    ovfset = (wv && !wok) ? NCHANEL'(1) << iid : '0;
    udfset = (rv && !rok) ? NCHANEL'(1) << rid : '0;
  end
  // A new event in the clear cycle still latches.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovfalm <= '0;
      udfalm <= '0;
    end else begin
      ovfalm <= (almclr ? '0 : ovfalm) | ovfset;
      udfalm <= (almclr ? '0 : udfalm) | udfset;
    end
`endif
endmodule
